ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/ifu_fifo.sv | 61 ++++++
 rtl/ifu_fetch.sv | 153 +++++++++++++++
 tb/tb_ifu_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC default, FSM state encoding and buffer entry layout
// for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int INS_WIDTH = 32;
    localparam logic [CPU_WIDTH-1:0] DEF_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [INS_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of {pc, instr} fetch entries with push, pop and flush.
// Flush has priority over push; storage is cleared only by reset.
module ifu_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_push,
    input  logic [CPU_WIDTH+INS_WIDTH-1:0] i_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output logic [CPU_WIDTH+INS_WIDTH-1:0] o_head,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CPU_WIDTH+INS_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]                  r_wr;
    logic [PW-1:0]                  r_rd;
    logic [CW-1:0]                  r_count;
    logic                           w_push;
    logic                           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding request FSM feeding a small
// {pc, instr} buffer. Define IFU_PERF_EN to add fetch/stall counters.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = DEF_RESET_PC,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_req_valid,
    output logic [CPU_WIDTH-1:0] o_req_addr,
    input  logic                 i_req_ready,
    input  logic                 i_rsp_valid,
    input  logic [INS_WIDTH-1:0] i_rsp_data,
    input  logic                 i_rsp_err,
    output logic [INS_WIDTH-1:0] o_instr,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_fetch_err
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]          o_perf_fetch,
    output logic [31:0]          o_perf_stall
`endif
);

    fetch_state_e         r_state;
    fetch_state_e         w_state_nxt;
    logic [CPU_WIDTH-1:0] r_pc;
    logic [CPU_WIDTH-1:0] w_pc_nxt;
    logic                 r_fetch_err;
    logic                 w_err_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_hs;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    fetch_entry_t         w_push_entry;
    fetch_entry_t         w_head;

    assign o_req_valid = (r_state == S_REQ) && !w_fifo_full;
    assign o_req_addr  = r_pc;
    assign w_hs        = o_req_valid & i_req_ready;
    assign o_valid     = !w_fifo_empty && (r_state != S_ERR);
    assign w_pop       = o_valid & i_ready;
    assign o_instr     = w_head.instr;
    assign o_pc        = w_head.pc;
    assign o_fetch_err = r_fetch_err;

    // Any redirect leaves WAIT, so in WAIT r_pc is always the request address + 4.
    assign w_push_entry.pc    = r_pc - 32'd4;
    assign w_push_entry.instr = i_rsp_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_err <= w_err_nxt;
        end
    end

    // A redirect takes priority over a same-cycle response, including an error one.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_fetch_err;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        if (r_state != S_ERR) begin
            if (i_redirect) begin
                w_flush  = 1'b1;
                w_pc_nxt = i_redirect_pc;
                if (i_redirect_pc[1:0] != 2'b00) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    case (r_state)
                        S_REQ:          w_state_nxt = w_hs ? S_DROP : S_REQ;
                        S_WAIT, S_DROP: w_state_nxt = i_rsp_valid ? S_REQ : S_DROP;
                        default:        w_state_nxt = r_state;
                    endcase
                end
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_hs) begin
                            w_pc_nxt    = r_pc + 32'd4;
                            w_state_nxt = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i_rsp_valid) begin
                            if (i_rsp_err) begin
                                w_err_nxt   = 1'b1;
                                w_flush     = 1'b1;
                                w_state_nxt = S_ERR;
                            end else begin
                                w_push      = 1'b1;
                                w_state_nxt = S_REQ;
                            end
                        end
                    end
                    S_DROP: begin
                        if (i_rsp_valid) w_state_nxt = S_REQ;
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef IFU_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (!o_valid && (r_state != S_ERR)) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign o_perf_fetch = r_perf_fetch;
    assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; the perf-counter scenario is
// compiled in only when IFU_PERF_EN is defined.
module tb_ifu_fetch;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_fetch_err;
`ifdef IFU_PERF_EN
    logic [31:0] o_perf_fetch;
    logic [31:0] o_perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch #(
        .RESET_PC   (32'h8000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_req_valid   (o_req_valid),
        .o_req_addr    (o_req_addr),
        .i_req_ready   (i_req_ready),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .i_rsp_err     (i_rsp_err),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fetch_err   (o_fetch_err)
`ifdef IFU_PERF_EN
        ,
        .o_perf_fetch  (o_perf_fetch),
        .o_perf_stall  (o_perf_stall)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_req_ready   = 1'b0;
        i_rsp_valid   = 1'b0;
        i_rsp_data    = '0;
        i_rsp_err     = 1'b0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // Handshake one request now, answer it lat cycles later.
    task automatic fetch_one(input logic [31:0] data, input int lat);
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        repeat (lat - 1) tick();
        i_rsp_valid = 1'b1;
        i_rsp_data  = data;
        tick();
        i_rsp_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        n_tests++; if (o_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid: got %b expected 1", o_req_valid); end
        n_tests++; if (o_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_addr0: got %h expected 80000000", o_req_addr); end
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        n_tests++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_noreq: got %b expected 0", o_req_valid); end
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0000_0013;
        tick();
        i_rsp_valid = 1'b0;
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", o_valid); end
        n_tests++; if (o_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_pc: got %h expected 80000000", o_pc); end
        n_tests++; if (o_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_instr: got %h expected 00000013", o_instr); end
        n_tests++; if (o_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL basic_addr1: got %h expected 80000004", o_req_addr); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got %b expected 0", o_valid); end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_ready = 1'b0;
        tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_tests++; if (o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", o_fetch_err); end
        n_tests++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", o_instr); end
        n_tests++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", o_pc); end
        i_rst_n = 1'b1;
        n_tests++; if (o_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 1", o_req_valid); end
        n_tests++; if (o_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 80000000", o_req_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_one(32'h0000_0100, 1);
        fetch_one(32'h0000_0104, 1);
        n_tests++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_noreq: got %b expected 0", o_req_valid); end
        repeat (8) tick();
        n_tests++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hold_noreq: got %b expected 0", o_req_valid); end
        n_tests++; if (o_req_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL bp_addr_hold: got %h expected 80000008", o_req_addr); end
        n_tests++; if (o_pc !== 32'h8000_0000 || o_instr !== 32'h100) begin n_fail++; $display("FAIL bp_head0: got %h/%h expected 80000000/00000100", o_pc, o_instr); end
        i_ready = 1'b1;
        tick();
        n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0004 || o_instr !== 32'h104) begin n_fail++; $display("FAIL bp_head1: got %b %h/%h expected 1 80000004/00000104", o_valid, o_pc, o_instr); end
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", o_valid); end
        n_tests++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL bp_resume: got %b %h expected 1 80000008", o_req_valid, o_req_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_one(32'h0000_000A, 1);
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0000_000B;
        i_ready     = 1'b1;
        tick();
        i_rsp_valid = 1'b0;
        i_ready     = 1'b0;
        n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0004 || o_instr !== 32'hB) begin n_fail++; $display("FAIL b2b_head: got %b %h/%h expected 1 80000004/0000000b", o_valid, o_pc, o_instr); end
        n_tests++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL b2b_occupancy: got %b %h expected 1 80000008", o_req_valid, o_req_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        fetch_one(32'h0000_0011, 1);
        i_req_ready = 1'b1;
        tick();
        i_req_ready   = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h8000_0100;
        tick();
        i_redirect = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_flush: got %b expected 0", o_valid); end
        n_tests++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_drop_noreq: got %b expected 0", o_req_valid); end
        tick();
        tick();
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'hDEAD_BEEF;
        tick();
        i_rsp_valid = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_discard: got %b expected 0", o_valid); end
        n_tests++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rdw_newreq: got %b %h expected 1 80000100", o_req_valid, o_req_addr); end
        fetch_one(32'h0000_0033, 1);
        n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0100 || o_instr !== 32'h33) begin n_fail++; $display("FAIL rdw_target: got %b %h/%h expected 1 80000100/00000033", o_valid, o_pc, o_instr); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        i_req_ready = 1'b1;
        tick();
        i_req_ready   = 1'b0;
        i_rsp_valid   = 1'b1;
        i_rsp_data    = 32'h0000_0077;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h8000_0200;
        tick();
        i_rsp_valid = 1'b0;
        i_redirect  = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_nopush: got %b expected 0", o_valid); end
        n_tests++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h8000_0200) begin n_fail++; $display("FAIL rdr_addr: got %b %h expected 1 80000200", o_req_valid, o_req_addr); end
        i_req_ready   = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h8000_0300;
        tick();
        i_req_ready = 1'b0;
        i_redirect  = 1'b0;
        n_tests++; if (o_req_valid !== 1'b0 || o_req_addr !== 32'h8000_0300) begin n_fail++; $display("FAIL rdr_hs_drop: got %b %h expected 0 80000300", o_req_valid, o_req_addr); end
        i_rsp_valid = 1'b1;
        i_rsp_err   = 1'b1;
        tick();
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
        n_tests++; if (o_valid !== 1'b0 || o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL rdr_drop_err: got valid %b err %b expected 0 0", o_valid, o_fetch_err); end
        n_tests++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h8000_0300) begin n_fail++; $display("FAIL rdr_after_drop: got %b %h expected 1 80000300", o_req_valid, o_req_addr); end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h8000_0400;
        tick();
        i_redirect = 1'b0;
        n_tests++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h8000_0400) begin n_fail++; $display("FAIL rdr_req_nohs: got %b %h expected 1 80000400", o_req_valid, o_req_addr); end
    endtask

    task automatic test_fetch_err();
        do_reset();
        fetch_one(32'h0000_0013, 1);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL err_first_ok: got %b expected 1", o_valid); end
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_err   = 1'b1;
        tick();
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
        n_tests++; if (o_fetch_err !== 1'b1 || o_valid !== 1'b0 || o_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_rsp: got err %b valid %b req %b expected 1 0 0", o_fetch_err, o_valid, o_req_valid); end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h8000_0000;
        i_req_ready   = 1'b1;
        i_ready       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (o_fetch_err !== 1'b1 || o_valid !== 1'b0 || o_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_halt%0d: got err %b valid %b req %b expected 1 0 0", k, o_fetch_err, o_valid, o_req_valid); end
        end
        do_reset();
        n_tests++; if (o_fetch_err !== 1'b0 || o_req_valid !== 1'b1) begin n_fail++; $display("FAIL err_cleared: got err %b req %b expected 0 1", o_fetch_err, o_req_valid); end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h8000_0102;
        tick();
        i_redirect_pc = 32'h8000_0200;
        tick();
        i_redirect = 1'b0;
        n_tests++; if (o_fetch_err !== 1'b1 || o_valid !== 1'b0 || o_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_misalign: got err %b valid %b req %b expected 1 0 0", o_fetch_err, o_valid, o_req_valid); end
    endtask

`ifdef IFU_PERF_EN
    task automatic test_perf();
        do_reset();
        i_ready = 1'b1;
        fetch_one(32'h0000_0001, 2);
        fetch_one(32'h0000_0002, 2);
        fetch_one(32'h0000_0003, 2);
        fetch_one(32'h0000_0004, 2);
        fetch_one(32'h0000_0005, 2);
        n_tests++; if (o_perf_fetch !== 32'd5) begin n_fail++; $display("FAIL perf_fetch: got %0d expected 5", o_perf_fetch); end
        n_tests++; if (o_perf_stall !== 32'd11) begin n_fail++; $display("FAIL perf_stall: got %0d expected 11", o_perf_stall); end
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_perf_stall !== 32'd11) begin n_fail++; $display("FAIL perf_stall_valid: got %0d expected 11", o_perf_stall); end
    endtask
`endif

    initial begin
        test_basic();
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_rsp();
        test_fetch_err();
`ifdef IFU_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
